fifo_uart_streamer: RTL and testbench

//  Drains acquired ADC samples from the memory-driver read FIFO and hands them to uart_control as 24-bit frames.

---
 rtl/fifo_uart_streamer.sv | 157 +++++++++++++++
 tb/tb_fifo_uart_streamer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_streamer.sv
// fifo_uart_streamer: drains 2-sample words from the ADC read FIFO and
// hands them to uart_control as frames, asking the memory driver for FIFO
// refills when the FIFO runs dry. Reports done or error to the controller.
//
// Handshakes: mem_read_strobe, fifo_rd_en and tx_send are single-cycle pulses
// and at most one of them is high in any cycle. fifo_rd_en is only raised
// while fifo_empty=0. tx_send is only raised while tx_ready=1. tx_frame is
// held from tx_send until uart_control reports tx_ready again. tx_error
// aborts the stream and takes priority over tx_ready in the same cycle.
module fifo_uart_streamer #(
    parameter int          SAMPLE_W   = 12,
    parameter int          CNT_W      = 23,
    parameter int          RD_LATENCY = 1,
    parameter logic [15:0] REFILL_TO  = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      sample_count,
    input  logic                  mem_ready,
    output logic                  mem_read_strobe,
    input  logic [2*SAMPLE_W-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic                  tx_ready,
    input  logic                  tx_error,
    output logic [2*SAMPLE_W-1:0] tx_frame,
    output logic                  tx_send,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [3:0]            dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CHECK  = 4'd1,
        S_REFILL = 4'd2,
        S_POP    = 4'd3,
        S_WAIT   = 4'd4,
        S_LATCH  = 4'd5,
        S_SEND   = 4'd6,
        S_ACK    = 4'd7,
        S_DONE   = 4'd8,
        S_ABORT  = 4'd9
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_remaining;
    logic [15:0]           r_to;
    logic [15:0]           w_to_inc;
    logic [7:0]            r_lat;
    logic [1:0]            r_guard;
    logic [2*SAMPLE_W-1:0] r_tx_frame;

    assign w_to_inc  = r_to + 16'd1;
    assign tx_frame  = r_tx_frame;
    assign dbg_state = r_state;
    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ABORT);
    assign done      = (r_state == S_DONE);
    assign error     = (r_state == S_ABORT);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode and the three single-cycle strobes.
    always_comb begin
        w_next          = r_state;
        mem_read_strobe = 1'b0;
        fifo_rd_en      = 1'b0;
        tx_send         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = (sample_count == '0) ? S_DONE : S_CHECK;
            end
            S_CHECK: begin
                if (tx_error)         w_next = S_ABORT;
                else if (!fifo_empty) w_next = S_POP;
                else if (mem_ready) begin
                    mem_read_strobe = 1'b1;
                    w_next          = S_REFILL;
                end
            end
            S_REFILL: begin
                if (tx_error)                    w_next = S_ABORT;
                else if (!fifo_empty)            w_next = S_POP;
                else if (w_to_inc >= REFILL_TO)  w_next = S_ABORT;
            end
            S_POP: begin
                if (tx_error)        w_next = S_ABORT;
                else if (fifo_empty) w_next = S_CHECK;
                else begin
                    fifo_rd_en = 1'b1;
                    w_next     = (RD_LATENCY > 1) ? S_WAIT : S_LATCH;
                end
            end
            S_WAIT: begin
                if (tx_error)                          w_next = S_ABORT;
                else if (r_lat >= 8'(RD_LATENCY - 1))  w_next = S_LATCH;
            end
            S_LATCH: begin
                w_next = tx_error ? S_ABORT : S_SEND;
            end
            S_SEND: begin
                if (tx_error) w_next = S_ABORT;
                else if (tx_ready) begin
                    tx_send = 1'b1;
                    w_next  = S_ACK;
                end
            end
            S_ACK: begin
                if (tx_error) w_next = S_ABORT;
                else if (r_guard == 2'd2 && tx_ready)
                    w_next = (r_remaining == '0) ? S_DONE : S_CHECK;
            end
            S_DONE:  w_next = S_IDLE;
            S_ABORT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Sample counter, refill timeout, read-latency wait, ack guard and frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_remaining <= '0;
            r_to        <= '0;
            r_lat       <= '0;
            r_guard     <= '0;
            r_tx_frame  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) r_remaining <= sample_count;
                // The strobe clock counts as the first clock of the refill wait.
                S_CHECK:  if (mem_read_strobe) r_to <= 16'd1;
                S_REFILL: r_to <= w_to_inc;
                S_POP:    r_lat <= 8'd1;
                S_WAIT:   r_lat <= r_lat + 8'd1;
                S_LATCH: begin
                    // A lone trailing sample travels with an all-zero partner.
                    if (r_remaining == CNT_W'(1))
                        r_tx_frame <= {fifo_data[2*SAMPLE_W-1:SAMPLE_W], {SAMPLE_W{1'b0}}};
                    else
                        r_tx_frame <= fifo_data;
                    r_remaining <= (r_remaining > CNT_W'(1)) ? r_remaining - CNT_W'(2) : '0;
                end
                S_SEND: r_guard <= 2'd0;
                S_ACK:  if (r_guard != 2'd2) r_guard <= r_guard + 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_streamer.sv
// Directed bench for fifo_uart_streamer: a small FIFO model with registered
// read data, a cycle-stamped monitor on the falling edge, and an expected
// frame queue per scenario.
module tb_fifo_uart_streamer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [22:0] sample_count;
    logic        mem_ready;
    logic        mem_read_strobe;
    logic [23:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        tx_ready;
    logic        tx_error;
    logic [23:0] tx_frame;
    logic        tx_send;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  dbg_state;

    fifo_uart_streamer #(
        .SAMPLE_W  (12),
        .CNT_W     (23),
        .RD_LATENCY(1),
        .REFILL_TO (16'd32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .sample_count   (sample_count),
        .mem_ready      (mem_ready),
        .mem_read_strobe(mem_read_strobe),
        .fifo_data      (fifo_data),
        .fifo_empty     (fifo_empty),
        .fifo_rd_en     (fifo_rd_en),
        .tx_ready       (tx_ready),
        .tx_error       (tx_error),
        .tx_frame       (tx_frame),
        .tx_send        (tx_send),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- FIFO model ----------------
    logic [23:0] fifo_mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    initial fifo_data = '0;
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= fifo_mem[6'(rd_ptr)];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          n_send = 0, n_strobe = 0, n_done = 0, n_error = 0, n_viol = 0;
    int          start_cyc = 0, strobe_cyc = 0, done_cyc = 0, error_cyc = 0, txerr_cyc = 0;
    logic [23:0] frame_log [0:63];
    int          send_cyc_log [0:63];

    always @(negedge clk) begin
        if (start) start_cyc = cyc;
        if (tx_error) txerr_cyc = cyc;
        if (mem_read_strobe) begin
            n_strobe   = n_strobe + 1;
            strobe_cyc = cyc;
        end
        if (tx_send) begin
            frame_log[6'(n_send)]    = tx_frame;
            send_cyc_log[6'(n_send)] = cyc;
            n_send = n_send + 1;
        end
        if (done) begin
            n_done   = n_done + 1;
            done_cyc = cyc;
        end
        if (error) begin
            n_error   = n_error + 1;
            error_cyc = cyc;
        end
        if (int'(mem_read_strobe) + int'(fifo_rd_en) + int'(tx_send) > 1) n_viol = n_viol + 1;
        if (fifo_rd_en && fifo_empty) n_viol = n_viol + 1;
        cyc = cyc + 1;
    end

    // ---------------- scoreboard ----------------
    logic [23:0] exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compares logged frames starting at index base against exp_q, in order.
    task automatic check_frames(input int base, input string tag);
        int idx;
        logic [23:0] e;
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s_frame%0d", tag, idx), 32'(frame_log[6'(base + idx)]), 32'(e));
            idx = idx + 1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [23:0] w);
        fifo_mem[6'(wr_ptr)] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic pulse_start(input logic [22:0] cnt);
        sample_count = cnt;
        start        = 1'b1;
        tick(1);
        start        = 1'b0;
    endtask

    // Waits (bounded) until done or error has pulsed since the snapshot base.
    task automatic wait_end(input int base, input int budget, input string tag);
        int k;
        k = 0;
        while ((n_done + n_error) == base && k < budget) begin
            tick(1);
            k = k + 1;
        end
        check({tag, "_end_seen"}, 32'((n_done + n_error) != base), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    int s_send, s_strobe, s_done, s_err, k;

    task automatic snap();
        s_send   = n_send;
        s_strobe = n_strobe;
        s_done   = n_done;
        s_err    = n_error;
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        sample_count = '0;
        mem_ready    = 1'b1;
        tx_ready     = 1'b0;
        tx_error     = 1'b0;
        tick(3);
        check("rst_outs", 32'({busy, done, error, tx_send, fifo_rd_en, mem_read_strobe}), 32'd0);
        check("rst_frame", 32'(tx_frame), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // 1: six samples, three words already in the FIFO, UART always ready.
        push_word(24'hABC123);
        push_word(24'h456789);
        push_word(24'hFED012);
        exp_q.push_back(24'hABC123);
        exp_q.push_back(24'h456789);
        exp_q.push_back(24'hFED012);
        tx_ready = 1'b1;
        snap();
        pulse_start(23'd6);
        check("t1_busy", 32'(busy), 32'd1);
        wait_end(s_done + s_err, 200, "t1");
        check("t1_sends", 32'(n_send - s_send), 32'd3);
        check("t1_latency", 32'(send_cyc_log[6'(s_send)] - start_cyc), 32'd4);
        check("t1_done_after_ack", 32'(done_cyc - send_cyc_log[6'(s_send + 2)]), 32'd4);
        check("t1_strobes", 32'(n_strobe - s_strobe), 32'd0);
        check("t1_done_cnt", 32'(n_done - s_done), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);
        check_frames(s_send, "t1");
        tick(3);

        // 2: odd count, third frame carries one sample with a zero partner.
        push_word(24'h111222);
        push_word(24'h333444);
        push_word(24'h555666);
        exp_q.push_back(24'h111222);
        exp_q.push_back(24'h333444);
        exp_q.push_back(24'h555000);
        snap();
        pulse_start(23'd5);
        wait_end(s_done + s_err, 200, "t2");
        tick(10);
        check("t2_sends", 32'(n_send - s_send), 32'd3);
        check("t2_done_cnt", 32'(n_done - s_done), 32'd1);
        check("t2_err_cnt", 32'(n_error - s_err), 32'd0);
        check_frames(s_send, "t2");

        // 3: empty FIFO; refill only once the memory driver reports ready.
        mem_ready = 1'b0;
        snap();
        pulse_start(23'd4);
        tick(3);
        check("t3_no_strobe_unready", 32'(n_strobe - s_strobe), 32'd0);
        check("t3_busy_wait", 32'(busy), 32'd1);
        mem_ready = 1'b1;
        k = 0;
        while (n_strobe == s_strobe && k < 20) begin
            tick(1);
            k = k + 1;
        end
        check("t3_strobe_seen", 32'(n_strobe - s_strobe), 32'd1);
        tick(10);
        push_word(24'h0C0D0E);
        push_word(24'hF0F1F2);
        exp_q.push_back(24'h0C0D0E);
        exp_q.push_back(24'hF0F1F2);
        wait_end(s_done + s_err, 200, "t3");
        check("t3_strobes", 32'(n_strobe - s_strobe), 32'd1);
        check("t3_sends", 32'(n_send - s_send), 32'd2);
        check("t3_done_cnt", 32'(n_done - s_done), 32'd1);
        check_frames(s_send, "t3");
        tick(3);

        // 4: FIFO never refills; timeout after 32 clocks.
        snap();
        pulse_start(23'd2);
        wait_end(s_done + s_err, 100, "t4");
        check("t4_err_cnt", 32'(n_error - s_err), 32'd1);
        check("t4_timeout_cycles", 32'(error_cyc - strobe_cyc), 32'd32);
        check("t4_sends", 32'(n_send - s_send), 32'd0);
        check("t4_done_cnt", 32'(n_done - s_done), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        tick(3);

        // 5: tx_error during the ack of frame 1 of 4, then a zero-length start.
        push_word(24'h0A0B0C);
        push_word(24'h1A1B1C);
        push_word(24'h2A2B2C);
        push_word(24'h3A3B3C);
        snap();
        pulse_start(23'd8);
        k = 0;
        while (n_send == s_send && k < 20) begin
            tick(1);
            k = k + 1;
        end
        check("t5_first_send", 32'(n_send - s_send), 32'd1);
        tx_error = 1'b1;
        tick(1);
        tx_error = 1'b0;
        tick(1);
        check("t5_err_cnt", 32'(n_error - s_err), 32'd1);
        check("t5_err_latency", 32'(error_cyc - txerr_cyc), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        tick(5);
        check("t5_sends", 32'(n_send - s_send), 32'd1);
        check("t5_done_cnt", 32'(n_done - s_done), 32'd0);
        snap();
        pulse_start(23'd0);
        wait_end(s_done + s_err, 10, "t5z");
        check("t5z_done_latency", 32'(done_cyc - start_cyc), 32'd1);
        check("t5z_sends", 32'(n_send - s_send), 32'd0);
        tick(3);

        // 6: reset while a frame waits in SEND, then a start while busy.
        tx_ready = 1'b0;
        snap();
        pulse_start(23'd4);
        tick(8);
        check("t6_stuck_busy", 32'(busy), 32'd1);
        check("t6_held_frame", 32'(tx_frame), 32'h1A1B1C);
        rst_n = 1'b0;
        tick(2);
        check("t6_rst_outs", 32'({busy, done, error, tx_send, fifo_rd_en, mem_read_strobe}), 32'd0);
        check("t6_rst_frame", 32'(tx_frame), 32'd0);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        tick(1);
        check("t6_no_pulse_on_reset", 32'((n_done - s_done) + (n_error - s_err)), 32'd0);
        snap();
        exp_q.push_back(24'h2A2B2C);
        pulse_start(23'd2);
        pulse_start(23'd6);
        wait_end(s_done + s_err, 100, "t6");
        tick(20);
        check("t6_sends", 32'(n_send - s_send), 32'd1);
        check("t6_done_cnt", 32'(n_done - s_done), 32'd1);
        check_frames(s_send, "t6");

        check("strobe_exclusive", 32'(n_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
